// File: rtl/note_sequencer.sv
// Plays the 16 note slots in order 1..15, 0 and drives a square-wave tone for each note.
// Latency: note word captured 3 clocks after slot fetch; each slot takes 3+NOTE_TICKS+GAP_TICKS clocks.
// Backpressure: none; start is ignored while busy, and stop aborts to idle on the next edge.
module note_sequencer #(
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [3:0]  rd_addr,
    input  logic [5:0]  rd_data,
    output logic [5:0]  note_out,
    input  logic [31:0] half_period,
    output logic        audio_out,
    output logic        busy,
    output logic [3:0]  slot,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LATCH,
        S_PLAY,
        S_GAP
    } state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] dur_cnt;
    logic [31:0] tone_cnt;
    logic [31:0] hp_reg;
    logic        play_last;
    logic        gap_last;

    assign slot = rd_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status decode; stop wins over every other transition.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        play_last = (dur_cnt == NOTE_LAST);
        gap_last  = (dur_cnt == GAP_LAST);
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_PLAY;
            S_PLAY:  if (play_last) state_nxt = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    if (rd_addr != 4'd0 || loop) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (stop) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: address sequencing, note capture, duration timing and tone generation.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            rd_addr   <= 4'd0;
            note_out  <= 6'd0;
            audio_out <= 1'b0;
            hp_reg    <= 32'd0;
            dur_cnt   <= 32'd0;
            tone_cnt  <= 32'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr <= 4'd1;
                    end
                end
                S_LATCH: begin
                    note_out <= rd_data;
                    dur_cnt  <= 32'd0;
                end
                S_PLAY: begin
                    // First PLAY edge freezes the half period so later changes are ignored.
                    if (dur_cnt == 32'd0) begin
                        hp_reg    <= half_period;
                        tone_cnt  <= 32'd0;
                        audio_out <= 1'b0;
                    end else if (hp_reg == 32'd0 || note_out[3:0] == 4'd0) begin
                        tone_cnt  <= 32'd0;
                        audio_out <= 1'b0;
                    end else if (tone_cnt == hp_reg - 32'd1) begin
                        tone_cnt  <= 32'd0;
                        audio_out <= ~audio_out;
                    end else begin
                        tone_cnt <= tone_cnt + 32'd1;
                    end
                    if (play_last) begin
                        dur_cnt   <= 32'd0;
                        tone_cnt  <= 32'd0;
                        audio_out <= 1'b0;
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    audio_out <= 1'b0;
                    if (gap_last) begin
                        dur_cnt <= 32'd0;
                        if (rd_addr != 4'd0) begin
                            rd_addr <= rd_addr + 4'd1;
                        end else if (loop) begin
                            rd_addr <= 4'd1;
                        end else begin
                            // Natural end of pass: return to idle values.
                            rd_addr  <= 4'd0;
                            note_out <= 6'd0;
                            hp_reg   <= 32'd0;
                            tone_cnt <= 32'd0;
                            done     <= 1'b1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop;
    logic [3:0]  rd_addr;
    logic [5:0]  rd_data;
    logic [5:0]  note_out;
    logic [31:0] half_period;
    logic        audio_out;
    logic        busy;
    logic [3:0]  slot;
    logic        done;

    note_sequencer #(.NOTE_TICKS(8), .GAP_TICKS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .rd_addr(rd_addr), .rd_data(rd_data), .note_out(note_out),
        .half_period(half_period), .audio_out(audio_out), .busy(busy),
        .slot(slot), .done(done)
    );

    always #5 clk = ~clk;

    // Registered note memory with two clocks from address change to valid data.
    logic [5:0] mem [16];
    logic [3:0] addr_q;
    always @(posedge clk) begin
        addr_q  <= rd_addr;
        rd_data <= mem[addr_q];
    end

    // Frequency selector stand-in: constant 3, or 0 for note 6'h15 when enabled.
    logic hpz;
    assign half_period = (hpz && note_out == 6'h15) ? 32'd0 : 32'd3;

    int total = 0;
    int passed = 0;
    int cyc;
    int dcount;
    bit log_en;
    logic [3:0] last_addr;
    int addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done) dcount++;
        if (log_en && rd_addr != last_addr) addr_log.push_back(int'(rd_addr));
        last_addr = rd_addr;
    endtask

    typedef struct {
        logic       start;
        logic [3:0] rd;
        logic       busy;
        logic       audio;
        logic [5:0] note;
    } vec_t;
    vec_t tbl[17];

    initial begin
        bit got;
        int done_cyc;
        int rest_bad;
        int a4;
        bit saw20;
        bit wrapped;
        logic [3:0] prev;

        for (int k = 0; k < 16; k++) mem[k] = {2'b01, 4'(k)};
        hpz = 1'b0; reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        cyc = 0; dcount = 0; log_en = 1'b0; last_addr = 4'd0;

        // Reset sequence, second cycle also requests start to show reset wins.
        step();
        start = 1'b1;
        step();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_note", note_out, 0);
        chk("rst_audio", audio_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot", slot, 0);
        chk("rst_done", done, 0);
        reset = 1'b0; start = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // First slot of a pass: start at v0, start pulse during PLAY at v5 is ignored.
        tbl[0]  = '{1'b1, 4'd1, 1'b1, 1'b0, 6'h00};
        tbl[1]  = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h00};
        tbl[2]  = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h00};
        tbl[3]  = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[4]  = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[5]  = '{1'b1, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[6]  = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[7]  = '{1'b0, 4'd1, 1'b1, 1'b1, 6'h11};
        tbl[8]  = '{1'b0, 4'd1, 1'b1, 1'b1, 6'h11};
        tbl[9]  = '{1'b0, 4'd1, 1'b1, 1'b1, 6'h11};
        tbl[10] = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[11] = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[12] = '{1'b0, 4'd1, 1'b1, 1'b0, 6'h11};
        tbl[13] = '{1'b0, 4'd2, 1'b1, 1'b0, 6'h11};
        tbl[14] = '{1'b0, 4'd2, 1'b1, 1'b0, 6'h11};
        tbl[15] = '{1'b0, 4'd2, 1'b1, 1'b0, 6'h11};
        tbl[16] = '{1'b0, 4'd2, 1'b1, 1'b0, 6'h12};

        log_en = 1'b1;
        addr_log.delete();
        cyc = -1;
        dcount = 0;
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start;
            step();
            start = 1'b0;
            chk($sformatf("v%0d_rd_addr", i), rd_addr, tbl[i].rd);
            chk($sformatf("v%0d_slot", i), slot, tbl[i].rd);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_audio", i), audio_out, tbl[i].audio);
            chk($sformatf("v%0d_note", i), note_out, tbl[i].note);
            chk($sformatf("v%0d_done", i), done, 0);
        end

        // Rest of the non-looping pass: done at 16*13 clocks after start.
        got = 1'b0; done_cyc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (done) begin got = 1'b1; done_cyc = cyc; end
        end
        chk("done_seen", got, 1);
        chk("done_time", done_cyc, 208);
        chk("end_busy", busy, 0);
        chk("end_rd_addr", rd_addr, 0);
        chk("end_note", note_out, 0);
        step();
        chk("done_one_cycle", done, 0);
        step(); step();
        chk("done_count", dcount, 1);
        log_en = 1'b0;
        chk("addr_seq_len", addr_log.size(), 16);
        for (int i = 0; i < 16 && i < addr_log.size(); i++)
            chk($sformatf("addr_seq_%0d", i), addr_log[i], (i + 1) % 16);

        // Looping pass with a rest on slot 3 and zero half period on slot 5.
        mem[3] = 6'h20; hpz = 1'b1; loop = 1'b1; dcount = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        rest_bad = 0; a4 = 0; saw20 = 1'b0; wrapped = 1'b0; prev = rd_addr;
        for (int i = 0; i < 400 && !wrapped; i++) begin
            step();
            if (busy && (rd_addr == 4'd3 || rd_addr == 4'd5) && audio_out) rest_bad++;
            if (rd_addr == 4'd4 && audio_out) a4++;
            if (rd_addr == 4'd3 && note_out == 6'h20) saw20 = 1'b1;
            if (prev == 4'd0 && rd_addr == 4'd1) begin
                wrapped = 1'b1;
                chk("loop_busy", busy, 1);
            end
            prev = rd_addr;
        end
        chk("loop_wrapped", wrapped, 1);
        chk("rest_silent", rest_bad, 0);
        chk("rest_note", saw20, 1);
        chk("slot4_tone", a4 > 0, 1);
        chk("loop_no_done", dcount, 0);

        // Stop in the fourth PLAY cycle of slot 7.
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (rd_addr == 4'd7) got = 1'b1;
        end
        chk("reach_slot7", got, 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (note_out == 6'h17) got = 1'b1;
        end
        chk("slot7_latched", got, 1);
        step(); step(); step();
        chk("pre_stop_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_rd_addr", rd_addr, 0);
        chk("stop_audio", audio_out, 0);
        chk("stop_note", note_out, 0);
        chk("stop_done", done, 0);
        step();
        chk("stop_done_after", done, 0);
        chk("stop_idle_hold", busy, 0);
        chk("stop_no_done_total", dcount, 0);

        // Restart after stop begins at slot 1.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_rd_addr", rd_addr, 1);
        chk("restart_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop2_busy", busy, 0);

        // Start and stop in the same idle cycle: stays idle.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_rd_addr", rd_addr, 0);
        step();
        chk("startstop_hold", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
